// File: rtl/tdm_serializer_4_pkg.sv
// Shared widths, FSM state type and select-stepping helper for the 4:1 TDM serializer.
package tdm_serializer_4_pkg;

    localparam int SEL_W = 2;
    localparam int NBITS = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Select walks upward for LSB-first frames and downward for MSB-first frames.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] cur,
                                                  input logic            msb_first);
        return msb_first ? (cur - 1'b1) : (cur + 1'b1);
    endfunction

endpackage

// File: rtl/mux_4_1.sv
// Combinational 4:1 bit-select cell: y is bit s of d.
module mux_4_1
    import tdm_serializer_4_pkg::*;
(
    input  logic [NBITS-1:0] d,
    input  logic [SEL_W-1:0] s,
    output logic             y
);

    assign y = d[s];

endmodule

// File: rtl/tdm_serializer_4.sv
// Accepts a 4-bit word over valid/ready and streams it out one bit per DIV-cycle slot
// by stepping the select of the 4:1 mux cell through all four positions.
module tdm_serializer_4
    import tdm_serializer_4_pkg::*;
#(
    parameter int DIV       = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [NBITS-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    output logic [SEL_W-1:0] sel,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam int               CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [SEL_W-1:0] START_SEL = MSB_FIRST ? SEL_W'(NBITS - 1) : '0;
    localparam logic [SEL_W-1:0] END_SEL   = MSB_FIRST ? '0 : SEL_W'(NBITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);

    generate
        if (DIV < 1 || DIV > 256) begin : g_bad_div
            $error("tdm_serializer_4: DIV must be in 1..256");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [NBITS-1:0]   data_q, data_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
    logic               mux_y;
    logic               shifting;
    logic               last_slot;
    logic               accept;

    mux_4_1 u_mux (
        .d (data_q),
        .s (sel_q),
        .y (mux_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            sel_q     <= START_SEL;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            sel_q     <= sel_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    // Ready opens in IDLE and in the final cycle of a frame, so a waiting word chains with no gap.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        sel_d     = sel_q;
        div_cnt_d = div_cnt_q;

        shifting  = (state_q == SHIFT);
        last_slot = shifting && (sel_q == END_SEL) && (div_cnt_q == CNT_LAST);
        in_ready  = !rst && ((state_q == IDLE) || last_slot);
        accept    = in_valid && in_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SHIFT;
                    data_d    = in_data;
                    sel_d     = START_SEL;
                    div_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (div_cnt_q == CNT_LAST) begin
                    div_cnt_d = '0;
                    if (last_slot) begin
                        sel_d = START_SEL;
                        if (accept) begin
                            data_d = in_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sel_d = next_sel(sel_q, MSB_FIRST);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ser_valid   = !rst && shifting;
        busy        = ser_valid;
        ser_out     = ser_valid && mux_y;
        sel         = rst ? '0 : sel_q;
        frame_start = ser_valid && (sel_q == START_SEL) && (div_cnt_q == '0);
        frame_done  = !rst && last_slot;
    end

endmodule

// File: doc/tdm_serializer_4.md
Name: tdm_serializer_4

Overview:
- Upstream sequencer for the team's 4:1 bit-select mux. Accepts a 4-bit parallel word over a valid/ready handshake, holds it, and steps the 2-bit select through all four positions to stream the word out one bit per slot.
- Sits between a parallel data producer and a single serial line.
- Internally instances the 4:1 select cell. The select index is also exported so downstream logic can tag each bit.

Parameters:
- DIV, 1, clock cycles per bit slot; legal range 1..256; 0 is illegal (elaboration error).
- MSB_FIRST, 0, 0 = select order 0,1,2,3; 1 = select order 3,2,1,0.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents a word.
- in_data  input  4  parallel word.
- in_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  current serial bit, equal to data_q[sel].
- sel  output  2  index of the bit currently driven.
- ser_valid  output  1  ser_out carries a live bit.
- frame_start  output  1  pulse in the first cycle of the first slot.
- frame_done  output  1  pulse in the last cycle of the last slot.
- busy  output  1  state is SHIFT.

Behaviour:
- Reset: while rst=1 at the edge, state=IDLE, data_q=0, sel=start index (0, or 3 if MSB_FIRST), div_cnt=0. All outputs are 0 while in reset, including in_ready.
- States and outputs:
  - IDLE: in_ready=1, ser_valid=0, ser_out=0, busy=0.
  - SHIFT: ser_valid=1, busy=1, ser_out=data_q[sel] via the mux cell, combinational from registered data_q/sel.
- Accept: an accept occurs when in_valid && in_ready at a rising edge. On accept, data_q<=in_data, sel<=start index, div_cnt<=0, state<=SHIFT. The first bit appears on ser_out in the cycle immediately after the accepting edge (latency 1). in_data is ignored when no accept occurs.
- Slot timing:
  - Each slot lasts exactly DIV cycles; div_cnt counts 0..DIV-1.
  - When div_cnt==DIV-1, sel advances: +1 if MSB_FIRST=0, -1 if MSB_FIRST=1.
  - div_cnt width is max(1, clog2(DIV)).
- Last slot: sel==end index (3, or 0 if MSB_FIRST) and div_cnt==DIV-1.
  - in_ready=1 combinationally in this cycle.
  - frame_done=1 in this cycle.
  - If in_valid=1, the new word is accepted, state stays SHIFT and the next frame starts with no gap.
  - Otherwise state returns to IDLE.
- in_ready=0 in every other SHIFT cycle; a producer holding in_valid must wait.
- frame_start=1 only when state==SHIFT, sel==start index and div_cnt==0.
- With DIV=1, frame_start and frame_done never coincide. With back-to-back frames, frame_done of frame N is immediately followed by frame_start of frame N+1.
- rst asserted mid-frame aborts the frame. The partial word is discarded and there is no frame_done pulse.
- ser_out must not change within a slot. It may change only on edges where sel or data_q updates.

Decomposition:
- Shared package: SEL_W=2, NBITS=4, the state enum (IDLE, SHIFT), and a function for next select index given MSB_FIRST.
- One sub-module: the existing combinational 4:1 bit-select cell mux_4_1 (d=data_q, s=sel, y=ser_out), instanced unchanged. All sequencing stays in tdm_serializer_4.

Test Plan:
- Reset then idle (DIV=1): assert rst 3 cycles, release -> in_ready=1, ser_valid=0, sel=0, frame_start=frame_done=0.
- Single word, DIV=1, MSB_FIRST=0: present in_data=4'b1011 for one cycle -> next 4 cycles ser_out=1,1,0,1 with sel=0,1,2,3; frame_start in cycle 1, frame_done in cycle 4; IDLE in cycle 5.
- DIV=3, MSB_FIRST=1, in_data=4'b0110 -> ser_out=0,1,1,0 with sel=3,2,1,0, each held 3 cycles (12 total); in_ready=0 for cycles 1-11 and 1 in cycle 12.
- Back-to-back, DIV=1: in_valid held high with words 4'hA then 4'h5 -> 8 consecutive ser_valid cycles, ser_out=0,1,0,1,1,0,1,0; frame_done cycle 4 followed directly by frame_start cycle 5.
- Stall: in_valid raised during slot 1 of a frame -> no accept until the last slot; word taken at the frame_done edge; in_data changes before then are ignored.
- Reset mid-frame (DIV=2): rst at slot 2 cycle 0 -> next cycle IDLE, ser_valid=0, no frame_done pulse; a new word 4'hF afterwards serializes normally as 1,1,1,1.
